// File: rtl/game_pkg.sv
// Shared types and constants for the 8x8 flap game core.
package game_pkg;
  localparam int MATRIX_DIM = 8;
  localparam int BIRD_COL   = 6;
  localparam int START_ROW  = 4;

  typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;
endpackage

// File: rtl/matrix_scan.sv
// Row scanner: drives one matrix row per cycle from the red/green frames.
module matrix_scan (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0][7:0] red,
  input  logic [7:0][7:0] green,
  output logic [7:0]      red_driver,
  output logic [7:0]      green_driver,
  output logic [7:0]      row_sink
);
  import game_pkg::*;

  logic       run_q;
  logic [2:0] scan_q;
  logic [7:0] red_col;
  logic [7:0] green_col;
  logic [7:0] red_drv_q;
  logic [7:0] green_drv_q;
  logic [7:0] sink_q;

  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_DIM; gi++) begin : g_col
      assign red_col[gi]   = red[gi][scan_q];
      assign green_col[gi] = green[gi][scan_q];
    end
  endgenerate

  // The first edge after reset release only arms the scanner, so row 0
  // reaches the pins on the second edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q       <= 1'b0;
      scan_q      <= 3'd0;
      red_drv_q   <= 8'h00;
      green_drv_q <= 8'h00;
      sink_q      <= 8'hFF;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        scan_q      <= scan_q + 3'd1;
        red_drv_q   <= red_col;
        green_drv_q <= green_col;
        sink_q      <= ~(8'd1 << scan_q);
      end
    end
  end

  assign red_driver   = red_drv_q;
  assign green_driver = green_drv_q;
  assign row_sink     = sink_q;
endmodule

// File: rtl/cc_driver_hit.sv
// Flap game core: dot position, gravity, press handling, crash detection,
// and matrix scan-out.
module cc_driver_hit #(
  parameter int FALL_DIV  = 256,
  parameter int START_ROW = game_pkg::START_ROW,
  parameter int BIRD_COL  = game_pkg::BIRD_COL
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            press,
  input  logic [7:0][7:0] red,
  output logic [7:0][7:0] green,
  output logic            crash,
  output logic [7:0]      red_driver,
  output logic [7:0]      green_driver,
  output logic [7:0]      row_sink
);
  import game_pkg::*;

  localparam int FW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;

  logic [2:0]    pos_q,   pos_d;
  logic [FW-1:0] fall_q,  fall_d;
  logic          crash_q, crash_d;
  matrix_t       green_d;
  logic          fall_tick;
  logic          pipe_hit;

  always_comb begin
    green_d = '0;
    green_d[BIRD_COL][pos_q] = 1'b1;
  end

  assign fall_tick = (fall_q == FW'(FALL_DIV - 1));
  assign pipe_hit  = |(red & green_d);

  // Press beats a gravity step; once crashed everything freezes.
  always_comb begin
    pos_d   = pos_q;
    fall_d  = fall_q;
    crash_d = crash_q;
    if (!crash_q) begin
      if (pipe_hit) crash_d = 1'b1;
      if (press) begin
        if (pos_q != 3'd7) pos_d = pos_q + 3'd1;
        fall_d = '0;
      end else if (fall_tick) begin
        fall_d = '0;
        if (pos_q != 3'd0) pos_d = pos_q - 3'd1;
        else               crash_d = 1'b1;
      end else begin
        fall_d = fall_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_q   <= 3'(START_ROW);
      fall_q  <= '0;
      crash_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      fall_q  <= fall_d;
      crash_q <= crash_d;
    end
  end

  assign green = green_d;
  assign crash = crash_q;

  matrix_scan u_scan (
    .clock        (clock),
    .reset        (reset),
    .red          (red),
    .green        (green_d),
    .red_driver   (red_driver),
    .green_driver (green_driver),
    .row_sink     (row_sink)
  );
endmodule

// File: tb/tb_cc_driver_hit.sv
// Directed bench for cc_driver_hit with a short gravity period.
module tb_cc_driver_hit;
  logic            clock;
  logic            reset;
  logic            press;
  logic [7:0][7:0] red;
  logic [7:0][7:0] green;
  logic            crash;
  logic [7:0]      red_driver;
  logic [7:0]      green_driver;
  logic [7:0]      row_sink;

  int n_checks = 0;
  int n_pass   = 0;

  cc_driver_hit #(.FALL_DIV(4), .START_ROW(4), .BIRD_COL(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .press        (press),
    .red          (red),
    .green        (green),
    .crash        (crash),
    .red_driver   (red_driver),
    .green_driver (green_driver),
    .row_sink     (row_sink)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] dot(input int r);
    logic [63:0] one;
    one = 64'd1;
    return one << (6 * 8 + r);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic press_tick();
    press = 1'b1;
    tick(1);
    press = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_sink;
    int row;
    reset = 1'b0;
    press = 1'b0;
    red   = '0;
    #12;
    check("rst_green", green, dot(4));
    check("rst_crash", crash, 1'b0);
    check("rst_sink", row_sink, 8'hFF);
    check("rst_rdrv", red_driver, 8'h00);
    check("rst_gdrv", green_driver, 8'h00);

    // Reset release and gravity
    @(negedge clock);
    reset = 1'b1;
    tick(1);
    check("rel_edge1_sink", row_sink, 8'hFF);
    tick(1);
    check("rel_edge2_sink", row_sink, 8'hFE);
    check("rel_edge2_gdrv", green_driver, 8'h00);
    tick(2);
    check("grav_4cyc", green, dot(3));
    tick(12);
    check("grav_16cyc", green, dot(0));
    check("grav_16_crash", crash, 1'b0);
    tick(3);
    check("grav_19_crash", crash, 1'b0);
    tick(1);
    check("ground_crash", crash, 1'b1);
    check("ground_green", green, dot(0));

    // Presses
    do_reset();
    press_tick(); press_tick(); press_tick();
    check("press3", green, dot(7));
    press_tick();
    check("press_sat", green, dot(7));
    tick(4);
    check("press_fall", green, dot(6));
    tick(3);
    press_tick();
    check("press_on_tick", green, dot(7));
    check("press_on_tick_crash", crash, 1'b0);
    tick(2);
    press_tick();
    tick(3);
    check("press_restart", green, dot(7));
    tick(1);
    check("press_restart_fall", green, dot(6));

    // Pipe hit and crash freeze
    do_reset();
    red[5][4] = 1'b1;
    tick(1);
    check("pipe_miss", crash, 1'b0);
    red = '0;
    red[6][4] = 1'b1;
    tick(1);
    check("pipe_hit", crash, 1'b1);
    red = '0;
    press_tick(); press_tick();
    tick(8);
    check("freeze_green", green, dot(4));
    check("freeze_crash", crash, 1'b1);

    // Scan of a known frame
    do_reset();
    red[2][3] = 1'b1;
    tick(4);
    check("scan_pos", green, dot(3));
    for (int i = 0; i < 7; i++) begin
      tick(1);
      row = (3 + i) % 8;
      exp_sink = ~(8'd1 << row);
      check($sformatf("scan_sink_r%0d", row), row_sink, exp_sink);
      check($sformatf("scan_rdrv_r%0d", row), red_driver, (row == 3) ? 8'h04 : 8'h00);
      check($sformatf("scan_gdrv_r%0d", row), green_driver, (row == 3) ? 8'h40 : 8'h00);
    end

    // Reset mid-scan after crash
    tick(9);
    check("scan_crash", crash, 1'b1);
    tick(2);
    check("pre_reset_sink", row_sink, 8'hEF);
    reset = 1'b0;
    #1;
    check("mid_rst_sink", row_sink, 8'hFF);
    check("mid_rst_rdrv", red_driver, 8'h00);
    check("mid_rst_gdrv", green_driver, 8'h00);
    check("mid_rst_crash", crash, 1'b0);
    check("mid_rst_green", green, dot(4));
    #20;
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cc_driver_hit.md
# cc_driver_hit

Game core of the 8x8 LED-matrix flap game. It holds the player dot's vertical position and shows it in green, moving it up on each press and pulling it down under gravity. It detects collisions between the dot and the red pipe field or the ground. It also time-multiplexes the red and green frame buffers onto the matrix column drivers and row sinks. It sits between the button-press conditioner and pipe generator upstream and the GPIO matrix pins and score logic downstream.

## Interface
Parameters:
- FALL_DIV, default 256: clock cycles per one-row gravity step.
- START_ROW, default 4: dot row after reset.
- BIRD_COL, default 6: fixed column of the dot.

Ports:
- clock  in  1: single clock; all state changes on its rising edge.
- reset  in  1: asynchronous, active-low (0 = reset).
- press  in  1: one-cycle pulse per button press, synchronous to clock.
- red  in  [7:0][7:0]: pipe frame, indexed [column][row]; row 0 is the bottom row.
- green  out  [7:0][7:0]: dot frame; exactly one bit set while alive.
- crash  out  1: sticky game-over flag.
- red_driver  out  8: red column drive for the scanned row; bit c = red[c][scan_row].
- green_driver  out  8: green column drive for the scanned row; bit c = green[c][scan_row].
- row_sink  out  8: active-low row select; only bit scan_row is 0.

## Operation
- Dot state:
  - 3-bit row register (pos), reset value START_ROW.
  - Fall counter, reset value 0.
  - green[BIRD_COL][pos] = 1; every other bit is 0.
- Press:
  - press=1 and crash=0: pos increments, saturating at 7, and the fall counter clears.
  - Press takes priority over a gravity step in the same cycle.
- Gravity:
  - When the fall counter reaches FALL_DIV-1, it wraps to 0.
  - If pos > 0, pos decrements.
  - If pos == 0, the ground-crash condition is set and pos stays 0.
- Collision: the pipe-crash condition is true when the bitwise AND of red and green has any bit set.
- crash:
  - Set to 1 on a ground crash or a pipe crash.
  - Stays 1 until reset.
  - While crash=1, pos and the fall counter freeze, press is ignored, and green keeps its last value.
- Scan:
  - A 3-bit scan_row increments every cycle and wraps 7→0.
  - Outputs are registered from the current scan_row.
  - Scanning continues while crash=1.
- Reset values:
  - pos = START_ROW; fall counter = 0; crash = 0; scan_row = 0.
  - red_driver = 8'h00, green_driver = 8'h00, row_sink = 8'hFF (all rows off).
  - green shows the dot at START_ROW.
- Reset can be asserted at any point, including mid-scan or after crash; all state returns to the values above immediately.

## Timing
- press → green update: 1 cycle (green is decoded from registered pos).
- Overlap present in a cycle → crash=1 at the next edge. Ground crash is set on the same edge as the gravity step that finds pos==0.
- Scan outputs for row k appear the cycle after scan_row==k. A full frame takes 8 cycles.
- red is sampled every cycle, with no handshake; it must be synchronous to clock.
- Reset release: the first scan output (row 0) appears on the second rising edge after release.

## Structure
- Shared package (game_pkg):
  - typedef matrix_t = logic [7:0][7:0].
  - Constants MATRIX_DIM=8, BIRD_COL, START_ROW.
- Top level cc_driver_hit contains the dot/gravity logic and the collision/crash register.
- Sub-module matrix_scan (clock, reset, red, green → red_driver, green_driver, row_sink) holds the scan counter and the output registers.

## Test plan
- Reset then idle (FALL_DIV=4):
  - After reset, green[6][4]=1 and crash=0.
  - After 4 cycles, pos=3.
  - After 20 cycles, pos reaches 0 and then crash=1.
- Press pulses:
  - Three presses from row 4 give pos=7.
  - A fourth press keeps pos at 7.
  - A press coinciding with a gravity tick gives pos+1 and restarts the fall counter.
- Pipe hit:
  - Drive red[6][4]=1 with the dot at row 4 → crash=1 next cycle.
  - red[5][4]=1 does not set crash.
- Crash freeze: after crash, presses and gravity ticks leave green unchanged; crash stays 1 until reset=0.
- Scan:
  - red[2][3]=1 and green[6][3]=1 → in the output cycle for row 3, row_sink=8'hF7, red_driver=8'h04, green_driver=8'h40.
  - All other rows show 8'h00 on both drivers.
- Mid-operation reset: assert reset during scan row 5 after a crash → outputs are immediately 00/00/FF, crash=0, and pos=4.
